// File: rtl/spi_pkg.sv
// Shared types, constants and SCLK edge helpers for the SPI peripheral.
package spi_pkg;

    localparam int unsigned SPI_MIN_OVERSAMPLE = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_state_t;

    function automatic logic spi_leading(input logic prev, input logic curr, input logic cpol);
        return (prev == cpol) && (curr != cpol);
    endfunction

    function automatic logic spi_trailing(input logic prev, input logic curr, input logic cpol);
        return (prev != cpol) && (curr == cpol);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, presetting to a chosen idle level on reset.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic clkIn,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Oversampled SPI responder with a single-word TX buffer; all logic runs on clkIn.
// Define SPI_PERIPHERAL_ERR_FLAGS_EN to add the sticky txUnderrun/frameAbort flags and errClr.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clkIn,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  csN,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  misoOe,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    output logic                  busy
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
    ,
    input  logic                  errClr,
    output logic                  txUnderrun,
    output logic                  frameAbort
`endif
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    logic sclk_sync, cs_sync, mosi_sync;
    logic sclk_prev_q, cs_prev_q;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .clkIn (clkIn),
        .rst   (rst),
        .d_i   (sclk),
        .q_o   (sclk_sync)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clkIn (clkIn),
        .rst   (rst),
        .d_i   (csN),
        .q_o   (cs_sync)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clkIn (clkIn),
        .rst   (rst),
        .d_i   (mosi),
        .q_o   (mosi_sync)
    );

    spi_state_t            state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_pend_q, rx_pend_d;
    logic                  rx_valid_q;
    logic                  reload_q, reload_d;
    logic                  skip_q, skip_d;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, tx_load, consume, underrun_set, abort_set;

    assign lead_edge   = spi_leading(sclk_prev_q, sclk_sync, CPOL);
    assign trail_edge  = spi_trailing(sclk_prev_q, sclk_sync, CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q & ~cs_sync;
    assign tx_load     = txValid & ~tx_full_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_data_d    = rx_data_q;
        rx_pend_d    = 1'b0;
        reload_d     = reload_q;
        skip_d       = skip_q;
        consume      = 1'b0;
        underrun_set = 1'b0;
        abort_set    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d      = SHIFT;
                    bit_cnt_d    = '0;
                    tx_shift_d   = tx_full_q ? tx_buf_q : '0;
                    consume      = tx_full_q;
                    underrun_set = ~tx_full_q;
                    reload_d     = 1'b0;
                    // With CPHA=1 the MSB is already on miso before the first leading edge
                    skip_d       = CPHA;
                end
            end
            SHIFT: begin
                // Deselect outranks any simultaneous SCLK edge
                if (cs_sync) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    reload_d   = 1'b0;
                    skip_d     = 1'b0;
                    abort_set  = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        rx_data_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                        rx_pend_d = 1'b1;
                        reload_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (reload_q) begin
                        reload_d     = 1'b0;
                        tx_shift_d   = tx_full_q ? tx_buf_q : '0;
                        consume      = tx_full_q;
                        underrun_set = ~tx_full_q;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load can only happen while empty and a consume only while full, so they never collide
        tx_buf_d  = tx_load ? txData : tx_buf_q;
        tx_full_d = tx_load ? 1'b1 : (consume ? 1'b0 : tx_full_q);
    end

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            reload_q    <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_sync;
            cs_prev_q   <= cs_sync;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_pend_q   <= rx_pend_d;
            rx_valid_q  <= rx_pend_q;
            reload_q    <= reload_d;
            skip_q      <= skip_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign misoOe  = (state_q == SHIFT);
    assign miso    = (state_q == SHIFT) & tx_shift_q[DATA_WIDTH-1];
    assign txReady = ~tx_full_q;
    assign rxData  = rx_data_q;
    assign rxValid = rx_valid_q;

`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
    logic underrun_q, abort_q;

    // Set wins over a same-cycle clear
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            underrun_q <= underrun_set | (underrun_q & ~errClr);
            abort_q    <= abort_set | (abort_q & ~errClr);
        end
    end

    assign txUnderrun = underrun_q;
    assign frameAbort = abort_q;
`else
    logic err_unused;
    assign err_unused = underrun_set ^ abort_set;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench: a mode-0 and a mode-3 instance driven by a behavioural SPI initiator model.
module tb_spi_peripheral;

    logic clkIn = 1'b0;
    logic rst   = 1'b1;
    always #5 clkIn = ~clkIn;

    logic        sclk [2];
    logic        cs_n [2];
    logic        mosi [2];
    logic        miso [2];
    logic        miso_oe [2];
    logic [15:0] tx_data [2];
    logic        tx_valid [2];
    logic        tx_ready [2];
    logic [15:0] rx_data [2];
    logic        rx_valid [2];
    logic        busy [2];
    logic        err_clr [2];
    logic        under [2];
    logic        abrt [2];

    spi_peripheral #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut0 (
        .clkIn   (clkIn),
        .rst     (rst),
        .sclk    (sclk[0]),
        .csN     (cs_n[0]),
        .mosi    (mosi[0]),
        .miso    (miso[0]),
        .misoOe  (miso_oe[0]),
        .txData  (tx_data[0]),
        .txValid (tx_valid[0]),
        .txReady (tx_ready[0]),
        .rxData  (rx_data[0]),
        .rxValid (rx_valid[0]),
        .busy    (busy[0])
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
        ,
        .errClr     (err_clr[0]),
        .txUnderrun (under[0]),
        .frameAbort (abrt[0])
`endif
    );

    spi_peripheral #(.DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut1 (
        .clkIn   (clkIn),
        .rst     (rst),
        .sclk    (sclk[1]),
        .csN     (cs_n[1]),
        .mosi    (mosi[1]),
        .miso    (miso[1]),
        .misoOe  (miso_oe[1]),
        .txData  (tx_data[1]),
        .txValid (tx_valid[1]),
        .txReady (tx_ready[1]),
        .rxData  (rx_data[1]),
        .rxValid (rx_valid[1]),
        .busy    (busy[1])
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
        ,
        .errClr     (err_clr[1]),
        .txUnderrun (under[1]),
        .frameAbort (abrt[1])
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int prev_rxv = 0;
    int last_rxv = 0;

    // Behavioural model state
    logic [15:0] mbuf [2];
    bit          mbuf_full [2];
    bit          m_under [2];
    bit          m_abort [2];
    bit          sel [2];
    int          hold [2];
    logic [16:0] expq [$];
    logic [15:0] got_log [$];

    always @(posedge clkIn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model; outputs are skipped for 3 cycles after any stimulus
    always @(negedge clkIn) begin
        for (int m = 0; m < 2; m++) begin
            if (rx_valid[m]) begin
                if (expq.size() == 0) begin
                    check("rx_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rx_word", {15'b0, m[0], rx_data[m]}, {15'b0, expq.pop_front()});
                end
                if (m == 0) begin
                    prev_rxv = last_rxv;
                    last_rxv = cyc;
                end
            end
            if (hold[m] > 0) begin
                hold[m]--;
            end else begin
                check("busy", {31'b0, busy[m]}, {31'b0, sel[m]});
                check("miso_oe", {31'b0, miso_oe[m]}, {31'b0, sel[m]});
                check("tx_ready", {31'b0, tx_ready[m]}, {31'b0, !mbuf_full[m]});
                if (!sel[m]) check("miso_idle", {31'b0, miso[m]}, 32'd0);
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
                check("tx_underrun", {31'b0, under[m]}, {31'b0, m_under[m]});
                check("frame_abort", {31'b0, abrt[m]}, {31'b0, m_abort[m]});
`endif
            end
        end
    end

    task automatic half(input int m);
        hold[m] = 3;
        repeat (4) @(posedge clkIn);
        #2;
    endtask

    task automatic pop_buf(input int m, output logic [15:0] w);
        if (mbuf_full[m]) begin
            w = mbuf[m];
            mbuf_full[m] = 0;
        end else begin
            w = '0;
            m_under[m] = 1;
        end
    endtask

    task automatic tx_load(input int m, input logic [15:0] w);
        check("tx_ready_before_load", {31'b0, tx_ready[m]}, 32'd1);
        tx_data[m]   = w;
        tx_valid[m]  = 1'b1;
        mbuf[m]      = w;
        mbuf_full[m] = 1;
        hold[m]      = 3;
        @(posedge clkIn);
        #2;
        tx_valid[m] = 1'b0;
    endtask

    task automatic err_clear(input int m);
        err_clr[m] = 1'b1;
        m_under[m] = 0;
        m_abort[m] = 0;
        hold[m]    = 3;
        @(posedge clkIn);
        #2;
        err_clr[m] = 1'b0;
    endtask

    task automatic check_reset(input int m);
        check("rst_rx_data", {16'b0, rx_data[m]}, 32'd0);
        check("rst_rx_valid", {31'b0, rx_valid[m]}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready[m]}, 32'd1);
        check("rst_miso", {31'b0, miso[m]}, 32'd0);
        check("rst_miso_oe", {31'b0, miso_oe[m]}, 32'd0);
        check("rst_busy", {31'b0, busy[m]}, 32'd0);
    endtask

    // SPI initiator: instance 0 runs mode 0, instance 1 runs mode 3.
    // stop_bits>0 ends the frame early after that many bits, by csN rise or by rst.
    task automatic do_frame(input int m, input int nwords, input logic [15:0] w0,
                            input logic [15:0] w1, input int stop_bits, input bit rst_stop,
                            input bit mid_load, input logic [15:0] mid_word);
        logic        cpol, cpha, stop;
        logic [15:0] rxw [2];
        logic [15:0] txw, cur, got;
        cpol   = (m == 1);
        cpha   = (m == 1);
        rxw[0] = w0;
        rxw[1] = w1;
        stop   = 1'b0;
        got    = '0;
        pop_buf(m, txw);
        sel[m]  = 1;
        cs_n[m] = 1'b0;
        mosi[m] = cpha ? 1'b0 : w0[15];
        half(m);
        for (int w = 0; w < nwords && !stop; w++) begin
            if (cpha && w > 0) pop_buf(m, txw);
            cur = txw;
            got = '0;
            for (int b = 0; b < 16 && !stop; b++) begin
                if (w == 0 && stop_bits > 0 && b == stop_bits) begin
                    stop = 1'b1;
                end else begin
                    if (cpha) mosi[m] = rxw[w][15-b];
                    else got[15-b] = miso[m];
                    if (!cpha && b == 15) expq.push_back({m[0], rxw[w]});
                    sclk[m] = ~cpol;
                    half(m);
                    if (cpha) got[15-b] = miso[m];
                    if (cpha && b == 15) expq.push_back({m[0], rxw[w]});
                    if (!cpha) begin
                        if (b < 15) mosi[m] = rxw[w][14-b];
                        else if (w + 1 < nwords) mosi[m] = rxw[w+1][15];
                        else mosi[m] = 1'b0;
                        if (b == 15) pop_buf(m, txw);
                    end
                    sclk[m] = cpol;
                    half(m);
                    if (mid_load && w == 0 && b == 7 && !mbuf_full[m]) tx_load(m, mid_word);
                end
            end
            if (!stop) begin
                check("miso_word", {16'b0, got}, {16'b0, cur});
                got_log.push_back(got);
            end
        end
        if (stop && rst_stop) begin
            rst = 1'b1;
            for (int i = 0; i < 2; i++) begin
                mbuf_full[i] = 0;
                m_under[i]   = 0;
                m_abort[i]   = 0;
                sel[i]       = 0;
                hold[i]      = 3;
            end
            #1;
            check_reset(m);
            cs_n[m] = 1'b1;
            sclk[m] = cpol;
            mosi[m] = 1'b0;
            @(posedge clkIn);
            #2;
            rst = 1'b0;
            half(m);
        end else begin
            cs_n[m] = 1'b1;
            mosi[m] = 1'b0;
            sel[m]  = 0;
            if (stop) m_abort[m] = 1;
            half(m);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] rw0, rw1;
        int          rm, rn;
        for (int i = 0; i < 2; i++) begin
            sclk[i] = (i == 1); cs_n[i] = 1'b1; mosi[i] = 1'b0; tx_data[i] = '0;
            tx_valid[i] = 1'b0; err_clr[i] = 1'b0; mbuf[i] = '0; mbuf_full[i] = 0;
            m_under[i] = 0; m_abort[i] = 0; sel[i] = 0; hold[i] = 0;
        end
        repeat (3) @(posedge clkIn);
        #2;
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        repeat (2) @(posedge clkIn);
        #2;

        // Mode 0: preloaded A55A out, 1234 in
        got_log.delete();
        tx_load(0, 16'hA55A);
        check("preload_tx_ready_low", {31'b0, tx_ready[0]}, 32'd0);
        do_frame(0, 1, 16'h1234, 16'h0000, 0, 0, 0, 16'h0);
        check("m0_rx_data", {16'b0, rx_data[0]}, 32'h1234);
        check("m0_miso_stream", {16'b0, got_log[0]}, 32'hA55A);
        check("m0_tx_ready_after", {31'b0, tx_ready[0]}, 32'd1);

        // Mode 3: 0F0F out, BEEF in
        got_log.delete();
        check("m3_miso_oe_before", {31'b0, miso_oe[1]}, 32'd0);
        tx_load(1, 16'h0F0F);
        do_frame(1, 1, 16'hBEEF, 16'h0000, 0, 0, 0, 16'h0);
        check("m3_rx_data", {16'b0, rx_data[1]}, 32'hBEEF);
        check("m3_miso_stream", {16'b0, got_log[0]}, 32'h0F0F);
        check("m3_miso_oe_after", {31'b0, miso_oe[1]}, 32'd0);

        // Two words back to back in one frame
        got_log.delete();
        tx_load(0, 16'h1111);
        do_frame(0, 2, 16'h0001, 16'h8000, 0, 0, 1, 16'h2222);
        check("b2b_rx_data", {16'b0, rx_data[0]}, 32'h8000);
        check("b2b_word0", {16'b0, got_log[0]}, 32'h1111);
        check("b2b_word1", {16'b0, got_log[1]}, 32'h2222);
        check("b2b_rxvalid_spacing", last_rxv - prev_rxv, 32'd128);

        // Underrun: nothing preloaded
        got_log.delete();
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
        err_clear(0);
        check("underrun_cleared", {31'b0, under[0]}, 32'd0);
`endif
        do_frame(0, 1, 16'hFFFF, 16'h0000, 0, 0, 0, 16'h0);
        check("underrun_miso_zero", {16'b0, got_log[0]}, 32'h0000);
        check("underrun_rx_data", {16'b0, rx_data[0]}, 32'hFFFF);
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
        check("underrun_flag_set", {31'b0, under[0]}, 32'd1);
        err_clear(0);
        repeat (2) @(posedge clkIn);
        #2;
        check("underrun_flag_clr", {31'b0, under[0]}, 32'd0);
`endif

        // Abort after 7 bits, then a clean frame
        do_frame(0, 1, 16'hC3A5, 16'h0000, 7, 0, 0, 16'h0);
        check("abort_rx_data_kept", {16'b0, rx_data[0]}, 32'hFFFF);
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
        check("abort_flag_set", {31'b0, abrt[0]}, 32'd1);
        err_clear(0);
`endif
        do_frame(0, 1, 16'h00FF, 16'h0000, 0, 0, 0, 16'h0);
        check("after_abort_rx", {16'b0, rx_data[0]}, 32'h00FF);

        // rst mid-frame after 5 bits, then a clean frame
        do_frame(0, 1, 16'h9999, 16'h0000, 5, 1, 0, 16'h0);
        do_frame(0, 1, 16'h5A5A, 16'h0000, 0, 0, 0, 16'h0);
        check("after_rst_rx", {16'b0, rx_data[0]}, 32'h5A5A);

        // Randomised frames on both instances
        for (int it = 0; it < 16; it++) begin
            rm  = int'($urandom_range(0, 1));
            rn  = int'($urandom_range(1, 2));
            rw0 = 16'($urandom);
            rw1 = 16'($urandom);
            if ($urandom_range(0, 1) == 1 && !mbuf_full[rm]) tx_load(rm, 16'($urandom));
            do_frame(rm, rn, rw0, rw1, 0, 0, 1'($urandom_range(0, 1)), 16'($urandom));
            check("rand_rx_data", {16'b0, rx_data[rm]}, {16'b0, (rn == 2) ? rw1 : rw0});
`ifdef SPI_PERIPHERAL_ERR_FLAGS_EN
            if ($urandom_range(0, 3) == 0) err_clear(rm);
`endif
        end

        repeat (8) @(posedge clkIn);
        #2;
        check("rx_queue_drained", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
